sr_mem_arbiter: RTL and testbench
=================================

# sr_mem_arbiter

Round-robin arbiter that shares one simple-memory request port (wr/addr/wdata/valid/ready request channel plus a single-cycle response pulse) between `NUM_REQ` requesting cores. It sits between the cores and the core-side AXI adapter. It allows one outstanding transaction at a time and latches the adapter's one-cycle response pulse into a holding register until the owning requester accepts it. A per-transaction timeout stops a lost response from deadlocking the port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 16: request address width.
- `DATA_WIDTH`, 32: read and write data width.
- `TIMEOUT`, 1024: maximum number of cycles spent in RESP; 0 disables the timeout.

One clock; reset is asynchronous and active-high.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_wr_i` in NUM_REQ: per-requester write flag (1 = write, 0 = read).
- `req_addr_i` in NUM_REQ*ADDR_WIDTH: packed addresses; requester k occupies `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata_i` in NUM_REQ*DATA_WIDTH: packed write data, same packing rule as addresses.
- `req_valid_i` in NUM_REQ: request valid.
- `req_ready_o` out NUM_REQ: request accepted.
- `resp_valid_o` out NUM_REQ: response valid; one-hot or zero.
- `resp_ready_i` in NUM_REQ: response accepted.
- `resp_rdata_o` out DATA_WIDTH: response data, shared by all requesters.
- `resp_err_o` out 1: set when the held response is a timeout.
- `mem_wr_o`, `mem_addr_o`, `mem_wdata_o` out 1/ADDR_WIDTH/DATA_WIDTH: forwarded request fields.
- `mem_req_valid_o` out 1 / `mem_req_ready_i` in 1: downstream request handshake.
- `mem_resp_valid_i` in 1: downstream one-cycle response pulse.
- `mem_resp_ready_o` out 1: downstream response ready.
- `mem_rdata_i` in DATA_WIDTH: downstream read data.
- `grant_o` out NUM_REQ: one-hot owner of the port; zero in IDLE.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
The arbiter is a four-state FSM: IDLE, REQ, RESP, DRAIN. Registered state is `gnt` (index), `ptr` (round-robin pointer), `rdata_q`, `err_q` and `tcnt`.

- **IDLE**
  - If any `req_valid_i` is high, set `gnt` to the first set bit searching upward from `ptr`, wrapping modulo NUM_REQ, and move to REQ.
- **REQ**
  - `mem_req_valid_o` = `req_valid_i[gnt]`.
  - `mem_wr_o`, `mem_addr_o` and `mem_wdata_o` carry requester `gnt`'s fields.
  - `req_ready_o[gnt]` = `mem_req_ready_i & req_valid_i[gnt]`, combinational.
  - On handshake, clear `tcnt` and move to RESP.
  - If `req_valid_i[gnt]` drops before a handshake (a protocol violation by the requester), return to IDLE with `ptr` unchanged.
- **RESP**
  - `mem_resp_ready_o` = 1 and `tcnt` increments every cycle.
  - When `mem_resp_valid_i` is high: `rdata_q` ← `mem_rdata_i`, `err_q` ← 0, move to DRAIN.
  - Otherwise, when `TIMEOUT` ≠ 0 and `tcnt` == TIMEOUT-1: `rdata_q` ← 0, `err_q` ← 1, move to DRAIN.
  - If the response and the timeout occur in the same cycle, the response wins.
- **DRAIN**
  - `resp_valid_o[gnt]` = 1, `resp_rdata_o` = `rdata_q`, `resp_err_o` = `err_q`.
  - When `resp_ready_i[gnt]` is high: `ptr` ← (`gnt`+1) mod NUM_REQ, move to IDLE.

Outside the states named above:
- `mem_*` outputs, `req_ready_o`, `resp_valid_o`, `resp_rdata_o` and `resp_err_o` are 0.
- A `mem_resp_valid_i` pulse that arrives outside RESP is dropped; this includes a late response after a timeout.
- `tcnt` is `$clog2(TIMEOUT+1)` bits wide and saturates; it does not wrap.
- The `ptr` increment wraps modulo NUM_REQ, so NUM_REQ-1 wraps to 0.

## Timing
- Reset values: state IDLE, `ptr` = 0, `gnt` = 0, `tcnt` = 0, `rdata_q` = 0, `err_q` = 0, every output 0.
- Reset asserted mid-transaction aborts the transaction immediately; the downstream adapter shares the same reset.
- Request arbitrated in cycle t: `mem_req_valid_o` rises at t+1.
- Handshake in cycle h: the state is RESP at h+1.
- Downstream response pulse in cycle r: `resp_valid_o[gnt]` rises at r+1.
- Requester accepts in cycle a: the next grant reaches REQ no earlier than a+2.
- `resp_valid_o` is held until accepted; `resp_rdata_o` is stable while it is held.
- Timeout: DRAIN is entered TIMEOUT cycles after the RESP entry cycle.

## Test plan
- **Single read:** requester 2 reads 0x1004 and the adapter returns 0xDEADBEEF 5 cycles after the handshake.
  - Expect `mem_addr_o` = 0x1004 and `mem_wr_o` = 0.
  - Expect `resp_valid_o` = 4'b0100 carrying 0xDEADBEEF with `resp_err_o` = 0.
  - Expect `ptr` = 3 afterwards.
- **Fairness:** all four requesters hold valid from reset and each is accepted immediately. Expect grant order 0, 1, 2, 3, 0 and no requester granted twice before all have been served.
- **Response backpressure:** hold `resp_ready_i` low for 10 cycles after the response.
  - `resp_valid_o` and `resp_rdata_o` must stay stable.
  - No new `mem_req_valid_o` while in DRAIN.
  - A second response pulse during DRAIN is ignored.
- **Write:** requester 1 writes 0x12345678 to 0x2000 and the adapter holds `mem_req_ready_i` low for 3 cycles. Expect `req_ready_o[1]` only in the ready cycle, then a response with `resp_err_o` = 0.
- **Timeout:** with TIMEOUT = 8, no response is returned. Expect DRAIN at RESP entry + 8 with `resp_err_o` = 1 and `resp_rdata_o` = 0; a late pulse in IDLE is ignored.
- **Reset and valid drop:**
  - Assert `rst` during RESP: all outputs go to 0 asynchronously and grant order restarts at requester 0.
  - Drop `req_valid_i[gnt]` while in REQ: expect return to IDLE with `ptr` unchanged.

Source files
------------

// File: rtl/sr_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around sr_mem_arbiter.
// The arbiter connects through the slave modport; the surrounding fabric uses master.
interface sr_mem_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_wr_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ-1:0]            resp_valid_o;
   logic [NUM_REQ-1:0]            resp_ready_i;
   logic [DATA_WIDTH-1:0]         resp_rdata_o;
   logic                          resp_err_o;
   logic                          mem_wr_o;
   logic [ADDR_WIDTH-1:0]         mem_addr_o;
   logic [DATA_WIDTH-1:0]         mem_wdata_o;
   logic                          mem_req_valid_o;
   logic                          mem_req_ready_i;
   logic                          mem_resp_valid_i;
   logic                          mem_resp_ready_o;
   logic [DATA_WIDTH-1:0]         mem_rdata_i;
   logic [NUM_REQ-1:0]            grant_o;
   logic                          busy_o;

   modport slave (
      input  req_wr_i, req_addr_i, req_wdata_i, req_valid_i, resp_ready_i,
             mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
             mem_wr_o, mem_addr_o, mem_wdata_o, mem_req_valid_o, mem_resp_ready_o,
             grant_o, busy_o
   );

   modport master (
      output req_wr_i, req_addr_i, req_wdata_i, req_valid_i, resp_ready_i,
             mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
             mem_wr_o, mem_addr_o, mem_wdata_o, mem_req_valid_o, mem_resp_ready_o,
             grant_o, busy_o
   );
endinterface

// File: rtl/sr_mem_arbiter.sv
// Round-robin arbiter sharing one simple-memory port between NUM_REQ cores,
// one outstanding transaction, with a held response and a response timeout.
module sr_mem_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 1024
) (
   input logic             clk,
   input logic             rst,
   sr_mem_arbiter_if.slave bus
);

   localparam int unsigned IDX_W  = $clog2(NUM_REQ);
   localparam int unsigned TCNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]            state, state_d;
   logic [IDX_W-1:0]      gnt, gnt_d;
   logic [IDX_W-1:0]      ptr, ptr_d;
   logic [TCNT_W-1:0]     tcnt, tcnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [IDX_W-1:0]      pick;
   logic [IDX_W-1:0]      cand;
   logic                  pick_found;

   logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

   // Unpack per-requester fields so the owner can be selected by index
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign addr_a[k]  = bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[k] = bus.req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // First valid requester at or above ptr, wrapping modulo NUM_REQ
   always_comb begin
      pick       = ptr;
      cand       = ptr;
      pick_found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
         if (!pick_found && bus.req_valid_i[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         gnt     <= '0;
         ptr     <= '0;
         tcnt    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_d;
         gnt     <= gnt_d;
         ptr     <= ptr_d;
         tcnt    <= tcnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      gnt_d   = gnt;
      ptr_d   = ptr;
      tcnt_d  = tcnt;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state)
         S_IDLE: begin
            if (|bus.req_valid_i) begin
               gnt_d   = pick;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // A requester withdrawing its request releases the port without advancing ptr
            if (!bus.req_valid_i[gnt]) begin
               state_d = S_IDLE;
            end else if (bus.mem_req_ready_i) begin
               tcnt_d  = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (tcnt != {TCNT_W{1'b1}}) begin
               tcnt_d = tcnt + TCNT_W'(1);
            end
            if (bus.mem_resp_valid_i) begin
               rdata_d = bus.mem_rdata_i;
               err_d   = 1'b0;
               state_d = S_DRAIN;
            end else if ((TIMEOUT != 0) && (tcnt == TCNT_W'(TIMEOUT - 1))) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.resp_ready_i[gnt]) begin
               ptr_d   = (32'(gnt) == NUM_REQ - 1) ? '0 : gnt + IDX_W'(1);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode from state so reset clears them without waiting for a clock edge
   always_comb begin
      bus.req_ready_o      = '0;
      bus.resp_valid_o     = '0;
      bus.resp_rdata_o     = '0;
      bus.resp_err_o       = 1'b0;
      bus.mem_wr_o         = 1'b0;
      bus.mem_addr_o       = '0;
      bus.mem_wdata_o      = '0;
      bus.mem_req_valid_o  = 1'b0;
      bus.mem_resp_ready_o = 1'b0;
      bus.grant_o          = '0;
      bus.busy_o           = 1'b0;
      if (state != S_IDLE) begin
         bus.busy_o  = 1'b1;
         bus.grant_o = NUM_REQ'(1) << gnt;
      end
      case (state)
         S_REQ: begin
            bus.mem_req_valid_o  = bus.req_valid_i[gnt];
            bus.mem_wr_o         = bus.req_wr_i[gnt];
            bus.mem_addr_o       = addr_a[gnt];
            bus.mem_wdata_o      = wdata_a[gnt];
            bus.req_ready_o[gnt] = bus.mem_req_ready_i & bus.req_valid_i[gnt];
         end
         S_RESP: bus.mem_resp_ready_o = 1'b1;
         S_DRAIN: begin
            bus.resp_valid_o[gnt] = 1'b1;
            bus.resp_rdata_o      = rdata_q;
            bus.resp_err_o        = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Self-checking bench for sr_mem_arbiter: directed scenarios plus random traffic,
// every output compared each cycle against a transaction-level reference model.
module tb_sr_mem_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   // What the model believes the arbiter owes the outside world
   localparam int PH_NONE  = 0;  // nothing owned
   localparam int PH_ISSUE = 1;  // presenting owner's request downstream
   localparam int PH_WAIT  = 2;  // waiting for downstream response
   localparam int PH_HOLD  = 3;  // offering held response to owner

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sr_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sr_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   int          m_phase, m_owner, m_ptr;
   logic [DW-1:0] m_rdata;
   logic        m_err;
   longint      cyc = 0;
   longint      m_deadline;

   int          grant_log[$];
   logic [N-1:0] prev_grant = '0;
   logic [N-1:0] obs_req_ready = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_NONE;
      m_ptr   = 0;
      m_owner = 0;
      m_rdata = '0;
      m_err   = 1'b0;
   endtask

   // Expected outputs from the model's obligations and the current inputs
   task automatic compare_all();
      logic [N-1:0]  oh, e_rr, e_rv, e_gnt;
      logic          e_mv, e_wr, e_mrr, e_err, e_busy;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_rd;
      oh = N'(1) << m_owner;
      e_rr = '0; e_rv = '0; e_gnt = '0; e_mv = 0; e_wr = 0; e_mrr = 0; e_err = 0; e_busy = 0;
      e_addr = '0; e_wd = '0; e_rd = '0;
      if (m_phase != PH_NONE) begin
         e_busy = 1'b1;
         e_gnt  = oh;
      end
      if (m_phase == PH_ISSUE) begin
         e_mv   = bus.req_valid_i[m_owner];
         e_wr   = bus.req_wr_i[m_owner];
         e_addr = bus.req_addr_i[m_owner*AW +: AW];
         e_wd   = bus.req_wdata_i[m_owner*DW +: DW];
         e_rr   = (bus.mem_req_ready_i && bus.req_valid_i[m_owner]) ? oh : '0;
      end
      if (m_phase == PH_WAIT) e_mrr = 1'b1;
      if (m_phase == PH_HOLD) begin
         e_rv  = oh;
         e_rd  = m_rdata;
         e_err = m_err;
      end
      check("busy",       bus.busy_o,           e_busy);
      check("grant",      bus.grant_o,          e_gnt);
      check("mem_valid",  bus.mem_req_valid_o,  e_mv);
      check("mem_wr",     bus.mem_wr_o,         e_wr);
      check("mem_addr",   bus.mem_addr_o,       e_addr);
      check("mem_wdata",  bus.mem_wdata_o,      e_wd);
      check("req_ready",  bus.req_ready_o,      e_rr);
      check("mresp_rdy",  bus.mem_resp_ready_o, e_mrr);
      check("resp_valid", bus.resp_valid_o,     e_rv);
      check("resp_rdata", bus.resp_rdata_o,     e_rd);
      check("resp_err",   bus.resp_err_o,       e_err);
   endtask

   // Advance the model across one rising edge using the inputs now applied
   task automatic model_advance();
      bit found;
      found = 0;
      case (m_phase)
         PH_NONE: begin
            for (int i = 0; i < N; i++) begin
               int c = (m_ptr + i) % N;
               if (!found && bus.req_valid_i[c]) begin
                  m_owner = c;
                  found   = 1;
               end
            end
            if (found) m_phase = PH_ISSUE;
         end
         PH_ISSUE: begin
            if (!bus.req_valid_i[m_owner]) m_phase = PH_NONE;
            else if (bus.mem_req_ready_i) begin
               m_phase    = PH_WAIT;
               m_deadline = cyc + TO;
            end
         end
         PH_WAIT: begin
            if (bus.mem_resp_valid_i) begin
               m_rdata = bus.mem_rdata_i;
               m_err   = 1'b0;
               m_phase = PH_HOLD;
            end else if (cyc == m_deadline) begin
               m_rdata = '0;
               m_err   = 1'b1;
               m_phase = PH_HOLD;
            end
         end
         default: begin
            if (bus.resp_ready_i[m_owner]) begin
               m_ptr   = (m_owner + 1) % N;
               m_phase = PH_NONE;
            end
         end
      endcase
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   // One clock cycle: called at a falling edge with inputs already applied
   task automatic step();
      #1;
      compare_all();
      if (bus.grant_o != '0 && prev_grant == '0) grant_log.push_back(onehot_idx(bus.grant_o));
      prev_grant    = bus.grant_o;
      obs_req_ready = bus.req_ready_o;
      model_advance();
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_wr_i[k]              = wr;
      bus.req_addr_i[k*AW +: AW]   = a;
      bus.req_wdata_i[k*DW +: DW]  = d;
   endtask

   // From the cycle the request is presented: accept, respond after lat cycles, drain
   task automatic finish_txn(input int lat);
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      repeat (lat) step();
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = $urandom;
      step();
      bus.mem_resp_valid_i = 1'b0;
      bus.resp_ready_i     = '1;
      step();
      bus.resp_ready_i     = '0;
   endtask

   task automatic serve_one(input int lat);
      step();
      finish_txn(lat);
   endtask

   task automatic rand_drive();
      for (int k = 0; k < N; k++) begin
         if (bus.req_valid_i[k] && obs_req_ready[k]) bus.req_valid_i[k] = 1'b0;
         else if (bus.req_valid_i[k] && $urandom_range(0, 49) == 0) bus.req_valid_i[k] = 1'b0;
         else if (!bus.req_valid_i[k] && $urandom_range(0, 3) == 0) begin
            set_req(k, 1'($urandom), AW'($urandom), $urandom);
            bus.req_valid_i[k] = 1'b1;
         end
      end
      bus.mem_req_ready_i  = ($urandom_range(0, 2) != 0);
      bus.mem_resp_valid_i = ($urandom_range(0, 5) == 0);
      bus.mem_rdata_i      = $urandom;
      bus.resp_ready_i     = N'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      bus.req_wr_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_valid_i = '0;
      bus.resp_ready_i = '0; bus.mem_req_ready_i = 1'b0; bus.mem_resp_valid_i = 1'b0;
      bus.mem_rdata_i = '0;
      model_reset();
      #1;
      compare_all();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Fairness: everyone requesting from reset
      for (int k = 0; k < N; k++) set_req(k, 1'($urandom), AW'($urandom), $urandom);
      bus.req_valid_i = '1;
      repeat (5) serve_one(1);
      bus.req_valid_i = '0;
      step();
      check("fair.count", 64'(grant_log.size()), 64'd5);
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         check("fair.order", 64'(grant_log[i]), 64'(exp_order[i]));

      // Single read by requester 2, response five cycles after the handshake
      set_req(2, 1'b0, 16'h1004, 32'h0);
      bus.req_valid_i[2] = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b1;
      #1;
      check("rd.addr", bus.mem_addr_o, 64'h1004);
      check("rd.wr", bus.mem_wr_o, 64'd0);
      check("rd.mvalid", bus.mem_req_valid_o, 64'd1);
      step();
      bus.mem_req_ready_i = 1'b0;
      bus.req_valid_i[2]  = 1'b0;
      repeat (4) step();
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'hDEADBEEF;
      step();
      bus.mem_resp_valid_i = 1'b0;
      #1;
      check("rd.rvalid", bus.resp_valid_o, 64'b0100);
      check("rd.rdata", bus.resp_rdata_o, 64'hDEADBEEF);
      check("rd.err", bus.resp_err_o, 64'd0);
      bus.resp_ready_i = 4'b0100;
      step();
      bus.resp_ready_i = '0;
      bus.req_valid_i  = '1;
      step();
      #1;
      check("rd.next_grant", bus.grant_o, 64'b1000);

      // Response backpressure on requester 3 with a stray second pulse
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      repeat (2) step();
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'hCAFE0003;
      step();
      bus.mem_resp_valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_rdata_i      = 32'h0BADF00D;
         end
         #1;
         check("bp.rvalid", bus.resp_valid_o, 64'b1000);
         check("bp.rdata", bus.resp_rdata_o, 64'hCAFE0003);
         check("bp.no_mreq", bus.mem_req_valid_o, 64'd0);
         step();
         bus.mem_resp_valid_i = 1'b0;
      end
      bus.resp_ready_i = 4'b1000;
      step();
      bus.resp_ready_i = '0;
      bus.req_valid_i  = '0;
      step();

      // Write by requester 1 with three cycles of downstream backpressure
      set_req(1, 1'b1, 16'h2000, 32'h12345678);
      bus.req_valid_i[1] = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         check("wr.not_ready", bus.req_ready_o, 64'd0);
         step();
      end
      bus.mem_req_ready_i = 1'b1;
      #1;
      check("wr.ready", bus.req_ready_o, 64'b0010);
      check("wr.wr", bus.mem_wr_o, 64'd1);
      check("wr.addr", bus.mem_addr_o, 64'h2000);
      check("wr.wdata", bus.mem_wdata_o, 64'h12345678);
      step();
      bus.mem_req_ready_i = 1'b0;
      bus.req_valid_i[1]  = 1'b0;
      repeat (3) step();
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'h0;
      step();
      bus.mem_resp_valid_i = 1'b0;
      #1;
      check("wr.rvalid", bus.resp_valid_o, 64'b0010);
      check("wr.err", bus.resp_err_o, 64'd0);
      bus.resp_ready_i = 4'b0010;
      step();
      bus.resp_ready_i = '0;

      // Timeout on requester 0, then a late pulse while idle
      set_req(0, 1'b0, 16'h3000, 32'h0);
      bus.req_valid_i[0] = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      bus.req_valid_i[0]  = 1'b0;
      repeat (TO - 1) step();
      #1;
      check("to.early", bus.resp_valid_o, 64'd0);
      step();
      #1;
      check("to.rvalid", bus.resp_valid_o, 64'b0001);
      check("to.err", bus.resp_err_o, 64'd1);
      check("to.rdata", bus.resp_rdata_o, 64'd0);
      bus.resp_ready_i = 4'b0001;
      step();
      bus.resp_ready_i     = '0;
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_rdata_i      = 32'h5555AAAA;
      step();
      bus.mem_resp_valid_i = 1'b0;
      #1;
      check("to.late_ignored", bus.busy_o, 64'd0);
      step();

      // Response arriving in the last cycle before timeout wins
      set_req(3, 1'b0, AW'($urandom), 32'h0);
      bus.req_valid_i = 4'b1000;
      serve_one(TO - 1);
      bus.req_valid_i = '0;
      step();

      // Requester withdraws while presented: ptr must not move
      bus.req_valid_i = 4'b0100;
      step();
      bus.req_valid_i     = '0;
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      #1;
      check("drop.idle", bus.busy_o, 64'd0);
      bus.req_valid_i = '1;
      step();
      #1;
      check("drop.grant", bus.grant_o, 64'b0001);
      finish_txn(1);

      // Reset in the middle of a response wait
      step();
      #1;
      check("rst.pre_grant", bus.grant_o, 64'b0010);
      bus.mem_req_ready_i = 1'b1;
      step();
      bus.mem_req_ready_i = 1'b0;
      step();
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      check("rst.busy", bus.busy_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_grant = '0;
      step();
      #1;
      check("rst.grant", bus.grant_o, 64'b0001);
      finish_txn(2);
      bus.req_valid_i = '0;
      step();

      // Random traffic
      for (int c = 0; c < 2000; c++) begin
         rand_drive();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
